// File: rtl/eq_pkg.sv
// Shared types and constants for the equalizer coefficient loader.
package eq_pkg;

  localparam int COEF_W   = 18;
  localparam int NUM_COEF = 5;

  // 1.0 in 4.14 fixed point: pass-through biquad.
  localparam logic [COEF_W-1:0] UNITY_B0 = 18'h04000;

  typedef enum logic [2:0] {
    SEL_B0 = 3'd0,
    SEL_B1 = 3'd1,
    SEL_B2 = 3'd2,
    SEL_A1 = 3'd3,
    SEL_A2 = 3'd4
  } coef_sel_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    RELEASE  = 2'd2
  } loader_state_e;

  // Reset value of a shadow coefficient: unity b0, everything else zero.
  function automatic logic [COEF_W-1:0] coef_reset_value(input int sel);
    if (sel == 0) begin
      return UNITY_B0;
    end else begin
      return {COEF_W{1'b0}};
    end
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter; the last-grant pointer lives in the parent.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx
);

  logic          w_found;
  logic [IW-1:0] w_cand;

  // Scan from last+1 around the ring and grant the first requester found.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int k = 1; k <= N; k++) begin
      w_cand = IW'((int'(i_last) + k) % N);
      if (!w_found && i_req[w_cand]) begin
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
        w_found         = 1'b1;
      end else begin
        w_found = w_found;
      end
    end
  end

endmodule

// File: rtl/eq_coeff_loader.sv
// Shadow coefficient store and serial loader for the biquad cascade.
module eq_coeff_loader #(
  parameter int NUM_BANDS   = 4,
  parameter int COEF_W      = 18,
  parameter int ACK_TIMEOUT = 255,
  localparam int BW = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 wr_en,
  input  logic [BW-1:0]        wr_band,
  input  logic [2:0]           wr_sel,
  input  logic [COEF_W-1:0]    wr_data,
  input  logic                 commit,
  input  logic [BW-1:0]        commit_band,
  input  logic                 sample_active,
  input  logic [NUM_BANDS-1:0] coefficients_updated,
  output logic [NUM_BANDS-1:0] new_coefficients,
  output logic [COEF_W-1:0]    b0_load,
  output logic [COEF_W-1:0]    b1_load,
  output logic [COEF_W-1:0]    b2_load,
  output logic [COEF_W-1:0]    a1_load,
  output logic [COEF_W-1:0]    a2_load,
  output logic [NUM_BANDS-1:0] pending,
  output logic                 busy,
  output logic                 timeout_err,
  input  logic                 err_clear
);

  import eq_pkg::*;

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  loader_state_e         r_state;
  logic [BW-1:0]         r_ptr;
  logic [BW-1:0]         r_cur;
  logic [NUM_BANDS-1:0]  r_pending;
  logic [NUM_BANDS-1:0]  r_new_coef;
  logic                  r_again;
  logic                  r_busy;
  logic                  r_timeout_err;
  logic [CW-1:0]         r_cnt;
  logic [COEF_W-1:0]     r_bus    [NUM_COEF];
  logic [COEF_W-1:0]     r_shadow [NUM_BANDS][NUM_COEF];

  logic [NUM_BANDS-1:0]  w_grant;
  logic [BW-1:0]         w_idx;
  logic [NUM_BANDS-1:0]  w_commit_vec;
  logic [NUM_BANDS-1:0]  w_pending_nxt;
  logic                  w_launch;
  logic                  w_ack_cur;
  logic                  w_to_hit;
  logic                  w_done;

  rr_arbiter #(.N(NUM_BANDS)) u_arb (
    .i_req   (r_pending),
    .i_last  (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  assign w_ack_cur = coefficients_updated[r_cur];
  assign w_to_hit  = (r_cnt == CW'(ACK_TIMEOUT - 1));
  assign w_launch  = (r_state == IDLE) && (|r_pending) && !sample_active;
  assign w_done    = (r_state == WAIT_ACK) && (w_ack_cur || w_to_hit);

  // Decode the commit strobe into a one-hot band vector.
  always_comb begin
    w_commit_vec = '0;
    if (commit) begin
      w_commit_vec[commit_band] = 1'b1;
    end else begin
      w_commit_vec = '0;
    end
  end

  // Completion clears the in-flight band unless it was re-committed; a new commit always wins.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_done && !r_again) begin
      w_pending_nxt[r_cur] = 1'b0;
    end else begin
      w_pending_nxt = r_pending;
    end
    w_pending_nxt = w_pending_nxt | w_commit_vec;
  end

  // Host-writable shadow coefficients; writes land regardless of transfer activity.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int b = 0; b < NUM_BANDS; b++) begin
        for (int s = 0; s < NUM_COEF; s++) begin
          r_shadow[b][s] <= coef_reset_value(s);
        end
      end
    end else if (wr_en) begin
      case (coef_sel_e'(wr_sel))
        SEL_B0, SEL_B1, SEL_B2, SEL_A1, SEL_A2: r_shadow[wr_band][wr_sel] <= wr_data;
        default: ;
      endcase
    end
  end

  // Pending-band bookkeeping.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  // Transfer FSM: launch snapshot, hold for acknowledge, wait for ack release.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state       <= IDLE;
      r_ptr         <= '0;
      r_cur         <= '0;
      r_new_coef    <= '0;
      r_again       <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_cnt         <= '0;
      for (int s = 0; s < NUM_COEF; s++) begin
        r_bus[s] <= '0;
      end
    end else begin
      // Clear first so a timeout in the same cycle keeps the flag set.
      if (err_clear) begin
        r_timeout_err <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (w_launch) begin
            r_cur      <= w_idx;
            r_ptr      <= w_idx;
            r_new_coef <= w_grant;
            r_cnt      <= '0;
            r_again    <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= WAIT_ACK;
            for (int s = 0; s < NUM_COEF; s++) begin
              r_bus[s] <= r_shadow[w_idx][s];
            end
          end else begin
            r_busy <= 1'b0;
          end
        end
        WAIT_ACK: begin
          // A commit for the band being delivered must trigger another pass.
          if (commit && (commit_band == r_cur)) begin
            r_again <= 1'b1;
          end
          if (w_ack_cur) begin
            r_new_coef <= '0;
            r_state    <= RELEASE;
          end else if (w_to_hit) begin
            r_new_coef    <= '0;
            r_timeout_err <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        RELEASE: begin
          if (!w_ack_cur) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_new_coef <= '0;
          r_busy     <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign new_coefficients = r_new_coef;
  assign b0_load          = r_bus[0];
  assign b1_load          = r_bus[1];
  assign b2_load          = r_bus[2];
  assign a1_load          = r_bus[3];
  assign a2_load          = r_bus[4];
  assign pending          = r_pending;
  assign busy             = r_busy;
  assign timeout_err      = r_timeout_err;

endmodule

// File: tb/tb_eq_coeff_loader.sv
// Directed self-checking bench for eq_coeff_loader with a simple biquad partner model.
module tb_eq_coeff_loader;

  logic        Clk;
  logic        Reset_n;
  logic        wr_en;
  logic [1:0]  wr_band;
  logic [2:0]  wr_sel;
  logic [17:0] wr_data;
  logic        commit;
  logic [1:0]  commit_band;
  logic        sample_active;
  logic [3:0]  coefficients_updated;
  logic [3:0]  new_coefficients;
  logic [17:0] b0_load, b1_load, b2_load, a1_load, a2_load;
  logic [3:0]  pending;
  logic        busy;
  logic        timeout_err;
  logic        err_clear;

  int n_total;
  int n_bad;
  logic partner_en;
  int pcnt [4];
  logic seen;

  eq_coeff_loader #(.NUM_BANDS(4), .COEF_W(18), .ACK_TIMEOUT(255)) dut (
    .Clk                  (Clk),
    .Reset_n              (Reset_n),
    .wr_en                (wr_en),
    .wr_band              (wr_band),
    .wr_sel               (wr_sel),
    .wr_data              (wr_data),
    .commit               (commit),
    .commit_band          (commit_band),
    .sample_active        (sample_active),
    .coefficients_updated (coefficients_updated),
    .new_coefficients     (new_coefficients),
    .b0_load              (b0_load),
    .b1_load              (b1_load),
    .b2_load              (b2_load),
    .a1_load              (a1_load),
    .a2_load              (a2_load),
    .pending              (pending),
    .busy                 (busy),
    .timeout_err          (timeout_err),
    .err_clear            (err_clear)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Biquad partner: one-cycle acknowledge pulse, first sampled 3 edges after the request rises.
  always @(negedge Clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!partner_en || !Reset_n) begin
        pcnt[i] = 0;
        coefficients_updated[i] = 1'b0;
      end else if (coefficients_updated[i]) begin
        coefficients_updated[i] = 1'b0;
      end else if (new_coefficients[i]) begin
        pcnt[i] = pcnt[i] + 1;
        if (pcnt[i] == 3) begin
          coefficients_updated[i] = 1'b1;
          pcnt[i] = 0;
        end
      end else begin
        pcnt[i] = 0;
      end
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic do_commit(input logic [1:0] band);
    commit = 1'b1;
    commit_band = band;
    tick(1);
    commit = 1'b0;
  endtask

  task automatic do_write(input logic [1:0] band, input logic [2:0] sel, input logic [17:0] data);
    wr_en = 1'b1;
    wr_band = band;
    wr_sel = sel;
    wr_data = data;
    tick(1);
    wr_en = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_bad = 0;
    Reset_n = 1'b0;
    wr_en = 1'b0;
    wr_band = 2'd0;
    wr_sel = 3'd0;
    wr_data = 18'h0;
    commit = 1'b0;
    commit_band = 2'd0;
    sample_active = 1'b0;
    err_clear = 1'b0;
    partner_en = 1'b1;
    coefficients_updated = 4'b0000;

    // Reset state
    tick(2);
    chk_eq("rst_newc", 32'(new_coefficients), 32'h0);
    chk_eq("rst_b0", 32'(b0_load), 32'h0);
    chk_eq("rst_pend", 32'(pending), 32'h0);
    chk_eq("rst_busy", 32'(busy), 32'h0);
    chk_eq("rst_terr", 32'(timeout_err), 32'h0);
    Reset_n = 1'b1;
    tick(1);

    // Band 2 with reset shadows
    do_commit(2'd2);
    chk_eq("t1_pend", 32'(pending), 32'h4);
    chk_eq("t1_nolaunch", 32'(new_coefficients), 32'h0);
    tick(1);
    chk_eq("t1_newc", 32'(new_coefficients), 32'h4);
    chk_eq("t1_b0", 32'(b0_load), 32'h04000);
    chk_eq("t1_b1", 32'(b1_load), 32'h0);
    chk_eq("t1_b2", 32'(b2_load), 32'h0);
    chk_eq("t1_a1", 32'(a1_load), 32'h0);
    chk_eq("t1_a2", 32'(a2_load), 32'h0);
    chk_eq("t1_busy", 32'(busy), 32'h1);
    tick(2);
    chk_eq("t1_hold", 32'(new_coefficients), 32'h4);
    tick(1);
    chk_eq("t1_drop", 32'(new_coefficients), 32'h0);
    chk_eq("t1_pclr", 32'(pending), 32'h0);
    tick(1);
    chk_eq("t1_idle", 32'(busy), 32'h0);

    // Band 1 held off by sample_active
    do_write(2'd1, 3'd1, 18'h3C000);
    do_write(2'd1, 3'd4, 18'h01000);
    do_write(2'd1, 3'd6, 18'h2AAAA);
    sample_active = 1'b1;
    do_commit(2'd1);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (new_coefficients != 4'b0000) seen = 1'b1;
      tick(1);
    end
    chk_eq("t2_blocked", 32'(seen), 32'h0);
    chk_eq("t2_pend", 32'(pending), 32'h2);
    sample_active = 1'b0;
    tick(1);
    chk_eq("t2_newc", 32'(new_coefficients), 32'h2);
    chk_eq("t2_b0", 32'(b0_load), 32'h04000);
    chk_eq("t2_b1", 32'(b1_load), 32'h3C000);
    chk_eq("t2_b2", 32'(b2_load), 32'h0);
    chk_eq("t2_a1", 32'(a1_load), 32'h0);
    chk_eq("t2_a2", 32'(a2_load), 32'h01000);
    tick(5);
    chk_eq("t2_idle", 32'(busy), 32'h0);

    // Band 0 re-written and re-committed during its own transfer
    do_commit(2'd0);
    tick(1);
    chk_eq("t4_newc", 32'(new_coefficients), 32'h1);
    chk_eq("t4_b0_old", 32'(b0_load), 32'h04000);
    wr_en = 1'b1;
    wr_band = 2'd0;
    wr_sel = 3'd0;
    wr_data = 18'h02000;
    commit = 1'b1;
    commit_band = 2'd0;
    tick(1);
    wr_en = 1'b0;
    commit = 1'b0;
    chk_eq("t4_b0_keep", 32'(b0_load), 32'h04000);
    tick(1);
    chk_eq("t4_pend", 32'(pending), 32'h1);
    tick(3);
    chk_eq("t4_newc2", 32'(new_coefficients), 32'h1);
    chk_eq("t4_b0_new", 32'(b0_load), 32'h02000);
    tick(5);
    chk_eq("t4_pclr", 32'(pending), 32'h0);
    chk_eq("t4_idle", 32'(busy), 32'h0);

    // Round robin with band 0 last served
    sample_active = 1'b1;
    do_commit(2'd0);
    do_commit(2'd1);
    do_commit(2'd3);
    chk_eq("t3_pend", 32'(pending), 32'hB);
    sample_active = 1'b0;
    tick(1);
    chk_eq("t3_first", 32'(new_coefficients), 32'h2);
    tick(5);
    chk_eq("t3_second", 32'(new_coefficients), 32'h8);
    tick(5);
    chk_eq("t3_third", 32'(new_coefficients), 32'h1);
    chk_eq("t3_b0", 32'(b0_load), 32'h02000);
    tick(5);
    chk_eq("t3_pclr", 32'(pending), 32'h0);
    chk_eq("t3_idle", 32'(busy), 32'h0);

    // Acknowledge timeout
    partner_en = 1'b0;
    do_commit(2'd3);
    tick(1);
    chk_eq("t5_newc", 32'(new_coefficients), 32'h8);
    tick(254);
    chk_eq("t5_still", 32'(new_coefficients), 32'h8);
    chk_eq("t5_noerr", 32'(timeout_err), 32'h0);
    tick(1);
    chk_eq("t5_drop", 32'(new_coefficients), 32'h0);
    chk_eq("t5_err", 32'(timeout_err), 32'h1);
    chk_eq("t5_pclr", 32'(pending), 32'h0);
    chk_eq("t5_busy", 32'(busy), 32'h0);
    tick(10);
    chk_eq("t5_sticky", 32'(timeout_err), 32'h1);
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    chk_eq("t5_clear", 32'(timeout_err), 32'h0);
    partner_en = 1'b1;

    // Asynchronous reset in WAIT_ACK
    do_commit(2'd2);
    tick(1);
    chk_eq("t6_newc", 32'(new_coefficients), 32'h4);
    tick(1);
    Reset_n = 1'b0;
    #1;
    chk_eq("t6_newc0", 32'(new_coefficients), 32'h0);
    chk_eq("t6_b0", 32'(b0_load), 32'h0);
    chk_eq("t6_pend", 32'(pending), 32'h0);
    chk_eq("t6_busy", 32'(busy), 32'h0);
    tick(2);
    Reset_n = 1'b1;
    tick(1);
    do_commit(2'd0);
    tick(1);
    chk_eq("t6_relaunch", 32'(new_coefficients), 32'h1);
    chk_eq("t6_shadow_rst", 32'(b0_load), 32'h04000);
    tick(5);
    chk_eq("t6_idle", 32'(busy), 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
